// File: rtl/tx_rd_req_tlp_gen_pkg.sv
// -----------------------------------------------------------------------------
// tx_rd_req_tlp_gen_pkg
// Shared definitions for the read-request TLP generator:
//   - Fmt/Type codes for 32- and 64-bit memory read requests
//   - cfg_max_rd_req_size encodings and a decode helper
//   - TRN remainder constants
//   - one-hot FSM state encodings
// -----------------------------------------------------------------------------
package tx_rd_req_tlp_gen_pkg;

    localparam logic [6:0] MRD32_FMT_TYPE = 7'b00_00000;
    localparam logic [6:0] MRD64_FMT_TYPE = 7'b01_00000;

    localparam logic [2:0] MAX_RD_REQ_128 = 3'b000;
    localparam logic [2:0] MAX_RD_REQ_256 = 3'b001;

    // Active-low byte-lane remainder: all 8 bytes valid / upper 4 bytes valid.
    localparam logic [7:0] TRN_REM_QW = 8'h00;
    localparam logic [7:0] TRN_REM_DW = 8'h0F;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_WAIT = 5'b00010,
        ST_HDR0 = 5'b00100,
        ST_HDR1 = 5'b01000,
        ST_NEXT = 5'b10000
    } rd_state_t;

    // Byte count of one read request; encodings above 256B all mean 512B,
    // and no request may exceed the chunk size.
    function automatic logic [12:0] decode_max_rd_req(input logic [2:0]  enc,
                                                      input logic [12:0] chunk_bytes);
        logic [12:0] size;
        case (enc)
            MAX_RD_REQ_128: size = 13'd128;
            MAX_RD_REQ_256: size = 13'd256;
            default:        size = 13'd512;
        endcase
        if (size > chunk_bytes) begin
            return chunk_bytes;
        end else begin
            return size;
        end
    endfunction

endpackage

// File: rtl/tx_rd_req_tlp_gen_hdr_builder.sv
// -----------------------------------------------------------------------------
// rd_tlp_hdr_builder
// Combinational MRd header formatter for a 64-bit TRN datapath.
//   addr          in  64  request byte address (bits [1:0] are not sent)
//   len           in  10  length in DW
//   tag           in  8   request tag
//   completer_id  in  16  requester ID {bus,dev,func}
//   qw0           out 64  header DW0/DW1
//   qw1           out 64  header DW2(/DW3); MRd32 leaves the low DW zero
//   rem_n         out 8   remainder for the qw1 beat
// A non-zero upper address word selects the 4DW (64-bit) header format.
// -----------------------------------------------------------------------------
module rd_tlp_hdr_builder
    import tx_rd_req_tlp_gen_pkg::*;
(
    input  logic [63:0] addr,
    input  logic [9:0]  len,
    input  logic [7:0]  tag,
    input  logic [15:0] completer_id,
    output logic [63:0] qw0,
    output logic [63:0] qw1,
    output logic [7:0]  rem_n
);

    logic       is_64_s;
    logic [6:0] fmt_type_s;
    logic       unused_addr_s;

    assign is_64_s    = (addr[63:32] != 32'h0000_0000);
    assign fmt_type_s = is_64_s ? MRD64_FMT_TYPE : MRD32_FMT_TYPE;

    // {R, Fmt/Type, R, TC, R, TD, EP, Attr, R, Length, ReqID, Tag, LastBE, FirstBE}
    assign qw0 = {1'b0, fmt_type_s, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00,
                  len, completer_id, tag, 4'hF, 4'hF};

    assign qw1 = is_64_s ? {addr[63:32], addr[31:2], 2'b00}
                         : {addr[31:2], 2'b00, 32'h0000_0000};

    assign rem_n = is_64_s ? TRN_REM_QW : TRN_REM_DW;

    assign unused_addr_s = ^addr[1:0];

endmodule

// File: rtl/tx_rd_req_tlp_gen.sv
// -----------------------------------------------------------------------------
// tx_rd_req_tlp_gen
// Splits each read_chunk request into MRd TLPs of at most the configured
// max-read-request size and sends them on the 64-bit TRN TX interface. The bus
// is claimed per TLP (so other sources can interleave) and read_chunk_ack
// pulses once the last TLP of the chunk has been accepted.
//   trn_clk, reset               clock / async active-high reset
//   read_chunk, huge_page_addr_read_from, read_chunk_ack   chunk handshake
//   cfg_max_rd_req_size, cfg_completer_id                  configuration
//   rd_req_turn, rd_req_driving                            TX arbitration
//   trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
//   trn_tdst_rdy_n, trn_tbuf_av                            TRN TX interface
// -----------------------------------------------------------------------------
module tx_rd_req_tlp_gen
    import tx_rd_req_tlp_gen_pkg::*;
#(
    parameter int CHUNK_BYTES = 512,
    parameter int TAG_BITS    = 5
) (
    input  logic        trn_clk,
    input  logic        reset,
    input  logic        read_chunk,
    input  logic [63:0] huge_page_addr_read_from,
    output logic        read_chunk_ack,
    input  logic [2:0]  cfg_max_rd_req_size,
    input  logic [15:0] cfg_completer_id,
    input  logic        rd_req_turn,
    output logic        rd_req_driving,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n,
    input  logic [5:0]  trn_tbuf_av
);

    localparam logic [12:0] CHUNK_B = 13'(CHUNK_BYTES);

    rd_state_t             state_r, state_s;
    logic [63:0]           addr_r, addr_s;
    logic [12:0]           remaining_r, remaining_s;
    logic [12:0]           req_bytes_r, req_bytes_s;
    logic [TAG_BITS-1:0]   tag_r, tag_s;
    logic                  ack_r, ack_s;
    logic                  driving_r, driving_s;
    logic [63:0]           td_r, td_s;
    logic [7:0]            rem_r, rem_s;
    logic                  sof_n_r, sof_n_s;
    logic                  eof_n_r, eof_n_s;
    logic                  src_rdy_n_r, src_rdy_n_s;

    logic [63:0]           qw0_s, qw1_s;
    logic [7:0]            hdr_rem_n_s;
    logic                  unused_in_s;

    rd_tlp_hdr_builder u_hdr (
        .addr         (addr_r),
        .len          (req_bytes_r[11:2]),
        .tag          (8'(tag_r)),
        .completer_id (cfg_completer_id),
        .qw0          (qw0_s),
        .qw1          (qw1_s),
        .rem_n        (hdr_rem_n_s)
    );

    // Next-state, datapath and registered-output values for the request FSM.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        remaining_s = remaining_r;
        req_bytes_s = req_bytes_r;
        tag_s       = tag_r;
        ack_s       = 1'b0;
        driving_s   = driving_r;
        td_s        = td_r;
        rem_s       = rem_r;
        sof_n_s     = sof_n_r;
        eof_n_s     = eof_n_r;
        src_rdy_n_s = src_rdy_n_r;
        case (state_r)
            ST_IDLE: begin
                // The cycle showing ack still sees the old request level.
                if (read_chunk && !ack_r) begin
                    addr_s      = huge_page_addr_read_from;
                    remaining_s = CHUNK_B;
                    req_bytes_s = decode_max_rd_req(cfg_max_rd_req_size, CHUNK_B);
                    state_s     = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (rd_req_turn && trn_tbuf_av[1]) begin
                    driving_s   = 1'b1;
                    td_s        = qw0_s;
                    rem_s       = TRN_REM_QW;
                    sof_n_s     = 1'b0;
                    eof_n_s     = 1'b1;
                    src_rdy_n_s = 1'b0;
                    state_s     = ST_HDR0;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HDR0: begin
                if (!trn_tdst_rdy_n) begin
                    td_s    = qw1_s;
                    rem_s   = hdr_rem_n_s;
                    sof_n_s = 1'b1;
                    eof_n_s = 1'b0;
                    state_s = ST_HDR1;
                end else begin
                    state_s = ST_HDR0;
                end
            end
            ST_HDR1: begin
                if (!trn_tdst_rdy_n) begin
                    td_s        = 64'h0;
                    rem_s       = 8'h00;
                    eof_n_s     = 1'b1;
                    src_rdy_n_s = 1'b1;
                    driving_s   = 1'b0;
                    tag_s       = tag_r + {{(TAG_BITS-1){1'b0}}, 1'b1};
                    addr_s      = addr_r + {51'h0, req_bytes_r};
                    remaining_s = remaining_r - req_bytes_r;
                    state_s     = ST_NEXT;
                end else begin
                    state_s = ST_HDR1;
                end
            end
            ST_NEXT: begin
                if (remaining_r == 13'd0) begin
                    ack_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                driving_s   = 1'b0;
                td_s        = 64'h0;
                rem_s       = 8'h00;
                sof_n_s     = 1'b1;
                eof_n_s     = 1'b1;
                src_rdy_n_s = 1'b1;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset drops any partial TLP.
    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= 64'h0;
            remaining_r <= 13'd0;
            req_bytes_r <= 13'd0;
            tag_r       <= '0;
            ack_r       <= 1'b0;
            driving_r   <= 1'b0;
            td_r        <= 64'h0;
            rem_r       <= 8'h00;
            sof_n_r     <= 1'b1;
            eof_n_r     <= 1'b1;
            src_rdy_n_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            remaining_r <= remaining_s;
            req_bytes_r <= req_bytes_s;
            tag_r       <= tag_s;
            ack_r       <= ack_s;
            driving_r   <= driving_s;
            td_r        <= td_s;
            rem_r       <= rem_s;
            sof_n_r     <= sof_n_s;
            eof_n_r     <= eof_n_s;
            src_rdy_n_r <= src_rdy_n_s;
        end
    end

    assign read_chunk_ack = ack_r;
    assign rd_req_driving = driving_r;
    assign trn_td         = td_r;
    assign trn_trem_n     = rem_r;
    assign trn_tsof_n     = sof_n_r;
    assign trn_teof_n     = eof_n_r;
    assign trn_tsrc_rdy_n = src_rdy_n_r;

    // Only the non-posted credit bit matters; length never exceeds 512B.
    assign unused_in_s = ^{trn_tbuf_av[5:2], trn_tbuf_av[0], req_bytes_r[12], req_bytes_r[1:0]};

endmodule

// File: tb/tb_tx_rd_req_tlp_gen.sv
// -----------------------------------------------------------------------------
// tb_tx_rd_req_tlp_gen
// Directed stimulus pushes expected TLP beats and ack events into a queue; an
// independent negedge monitor pops and compares on every accepted beat and
// every ack pulse, and also checks beat stability under back-pressure and bus
// release after each EOF.
// -----------------------------------------------------------------------------
module tb_tx_rd_req_tlp_gen;

    logic        trn_clk = 1'b0;
    logic        reset;
    logic        read_chunk;
    logic [63:0] huge_page_addr_read_from;
    logic        read_chunk_ack;
    logic [2:0]  cfg_max_rd_req_size;
    logic [15:0] cfg_completer_id;
    logic        rd_req_turn;
    logic        rd_req_driving;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;
    logic [5:0]  trn_tbuf_av;

    tx_rd_req_tlp_gen dut (
        .trn_clk                  (trn_clk),
        .reset                    (reset),
        .read_chunk               (read_chunk),
        .huge_page_addr_read_from (huge_page_addr_read_from),
        .read_chunk_ack           (read_chunk_ack),
        .cfg_max_rd_req_size      (cfg_max_rd_req_size),
        .cfg_completer_id         (cfg_completer_id),
        .rd_req_turn              (rd_req_turn),
        .rd_req_driving           (rd_req_driving),
        .trn_td                   (trn_td),
        .trn_trem_n               (trn_trem_n),
        .trn_tsof_n               (trn_tsof_n),
        .trn_teof_n               (trn_teof_n),
        .trn_tsrc_rdy_n           (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n           (trn_tdst_rdy_n),
        .trn_tbuf_av              (trn_tbuf_av)
    );

    always #2 trn_clk = ~trn_clk;

    typedef struct packed {
        logic        is_ack;
        logic [63:0] td;
        logic [7:0]  rem_n;
        logic        sof_n;
        logic        eof_n;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_tag = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push_beat(input logic [63:0] td, input logic [7:0] rem_n,
                                      input logic sof_n, input logic eof_n);
        exp_t b;
        b.is_ack = 1'b0;
        b.td     = td;
        b.rem_n  = rem_n;
        b.sof_n  = sof_n;
        b.eof_n  = eof_n;
        sb_q.push_back(b);
    endfunction

    function automatic void push_ack();
        exp_t b;
        b = '0;
        b.is_ack = 1'b1;
        sb_q.push_back(b);
    endfunction

    // Reference TLP: DW0 is 0x2000_0000 for a 4DW header, plus length in DW.
    function automatic void push_tlp(input logic [63:0] a, input int req, input int tag);
        logic [31:0] dw0;
        logic [31:0] dw1;
        logic [31:0] lo;
        logic [31:0] hi;
        hi  = a[63:32];
        lo  = a[31:0] & 32'hFFFF_FFFC;
        dw0 = (hi != 32'h0) ? 32'h2000_0000 : 32'h0000_0000;
        dw0 = dw0 | 32'(req / 4);
        dw1 = {cfg_completer_id, 8'(tag), 8'hFF};
        push_beat({dw0, dw1}, 8'h00, 1'b0, 1'b1);
        if (hi != 32'h0) push_beat({hi, lo}, 8'h00, 1'b1, 1'b0);
        else             push_beat({lo, 32'h0}, 8'h0F, 1'b1, 1'b0);
    endfunction

    // Monitor: compares every accepted beat and ack pulse against the queue.
    initial begin
        exp_t e;
        exp_t prev_beat;
        logic prev_stall;
        logic prev_eof_acc;
        logic got;
        int   since_eof;
        prev_stall   = 1'b0;
        prev_eof_acc = 1'b0;
        since_eof    = 100;
        prev_beat    = '0;
        forever begin
            @(negedge trn_clk);
            if (reset) begin
                prev_stall   = 1'b0;
                prev_eof_acc = 1'b0;
                since_eof    = 100;
            end else begin
                if (since_eof < 100) since_eof++;
                if (prev_eof_acc) check_eq("bus_release", rd_req_driving, 1'b0);
                prev_eof_acc = 1'b0;
                if (!trn_tsrc_rdy_n) check_eq("driving_while_valid", rd_req_driving, 1'b1);
                if (prev_stall) begin
                    check_eq("stall_td",  trn_td,     prev_beat.td);
                    check_eq("stall_rem", trn_trem_n, prev_beat.rem_n);
                    check_eq("stall_sof", trn_tsof_n, prev_beat.sof_n);
                    check_eq("stall_eof", trn_teof_n, prev_beat.eof_n);
                end
                prev_stall = !trn_tsrc_rdy_n && trn_tdst_rdy_n;
                prev_beat  = {1'b0, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n};
                if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
                    got = (sb_q.size() != 0) && !sb_q[0].is_ack;
                    check_eq("beat_expected", got, 1'b1);
                    if (got) begin
                        e = sb_q.pop_front();
                        check_eq("beat_td",  trn_td,     e.td);
                        check_eq("beat_rem", trn_trem_n, e.rem_n);
                        check_eq("beat_sof", trn_tsof_n, e.sof_n);
                        check_eq("beat_eof", trn_teof_n, e.eof_n);
                    end
                    if (!trn_teof_n) begin
                        prev_eof_acc = 1'b1;
                        since_eof    = 0;
                    end
                end
                if (read_chunk_ack) begin
                    got = (sb_q.size() != 0) && sb_q[0].is_ack;
                    check_eq("ack_expected", got, 1'b1);
                    if (got) e = sb_q.pop_front();
                    check_eq("ack_latency", 64'(since_eof), 64'd2);
                end
            end
        end
    end

    // mode: 0 plain (checks 2-cycle SOF latency), 1 stall 3 cycles in HDR1,
    //       2 credit/turn blocked in WAIT, 3 cfg changes mid-chunk.
    task automatic run_chunk(input logic [63:0] addr, input logic [2:0] max,
                             input int mode, input bit use_model);
        int req;
        int ntlp;
        int cyc;
        int stall_cnt;
        bit done;
        bit first_sof;
        req  = (max == 3'b000) ? 128 : (max == 3'b001) ? 256 : 512;
        ntlp = 512 / req;
        for (int i = 0; i < ntlp; i++) begin
            if (use_model) push_tlp(addr + 64'(i * req), req, exp_tag);
            exp_tag = (exp_tag + 1) % 32;
        end
        push_ack();
        @(posedge trn_clk); #1;
        huge_page_addr_read_from = addr;
        cfg_max_rd_req_size      = max;
        if (mode == 2) begin
            rd_req_turn = 1'b1;
            trn_tbuf_av = 6'b000000;
        end
        read_chunk = 1'b1;
        cyc = 0; stall_cnt = 0; done = 1'b0; first_sof = 1'b0;
        while (!done && cyc < 400) begin
            @(posedge trn_clk); #1;
            cyc++;
            if (!first_sof && !trn_tsof_n) begin
                first_sof = 1'b1;
                if (mode == 0) check_eq("sof_latency", 64'(cyc), 64'd2);
                if (mode == 2) check_eq("sof_after_unblock", 64'(cyc), 64'd9);
            end
            if (mode == 1) begin
                if (!trn_teof_n && !trn_tsrc_rdy_n && stall_cnt < 3) begin
                    trn_tdst_rdy_n = 1'b1;
                    stall_cnt++;
                end else begin
                    trn_tdst_rdy_n = 1'b0;
                end
            end
            if (mode == 2) begin
                if (cyc <= 8) check_eq("no_sof_while_blocked", trn_tsrc_rdy_n, 1'b1);
                if (cyc < 5) begin
                    rd_req_turn = 1'b1; trn_tbuf_av = 6'b000000;
                end else if (cyc < 8) begin
                    rd_req_turn = 1'b0; trn_tbuf_av = 6'b000010;
                end else begin
                    rd_req_turn = 1'b1; trn_tbuf_av = 6'b000010;
                end
            end
            if (mode == 3 && cyc == 3) cfg_max_rd_req_size = 3'b010;
            if (read_chunk_ack) begin
                done = 1'b1;
                read_chunk = 1'b0;
            end
        end
        check_eq("chunk_ack_seen", done, 1'b1);
        read_chunk     = 1'b0;
        trn_tdst_rdy_n = 1'b0;
        rd_req_turn    = 1'b1;
        trn_tbuf_av    = 6'b000010;
        repeat (2) @(posedge trn_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b1;
        read_chunk = 1'b0;
        huge_page_addr_read_from = 64'h0;
        cfg_max_rd_req_size = 3'b010;
        cfg_completer_id = 16'h0100;
        rd_req_turn = 1'b1;
        trn_tdst_rdy_n = 1'b0;
        trn_tbuf_av = 6'b000010;
        repeat (3) @(posedge trn_clk);
        @(negedge trn_clk);
        check_eq("rst_ack",     read_chunk_ack, 1'b0);
        check_eq("rst_driving", rd_req_driving, 1'b0);
        check_eq("rst_td",      trn_td,         64'h0);
        check_eq("rst_rem",     trn_trem_n,     8'h00);
        check_eq("rst_sof",     trn_tsof_n,     1'b1);
        check_eq("rst_eof",     trn_teof_n,     1'b1);
        check_eq("rst_src_rdy", trn_tsrc_rdy_n, 1'b1);
        @(posedge trn_clk); #1;
        reset = 1'b0;

        // MRd64, one 512B TLP, tag 0
        push_beat(64'h2000_0080_0100_00FF, 8'h00, 1'b0, 1'b1);
        push_beat(64'h0000_0001_2340_0200, 8'h00, 1'b1, 1'b0);
        run_chunk(64'h0000_0001_2340_0200, 3'b010, 0, 1'b0);

        // MRd32, tag 1
        push_beat(64'h0000_0080_0100_01FF, 8'h00, 1'b0, 1'b1);
        push_beat(64'h8000_0400_0000_0000, 8'h0F, 1'b1, 1'b0);
        run_chunk(64'h0000_0000_8000_0400, 3'b010, 0, 1'b0);

        // 4 x 128B, cfg change mid-chunk must not matter
        run_chunk(64'h0000_0000_0001_0000, 3'b000, 3, 1'b1);
        // back-pressure on the EOF beat, encoding 101 clamps to 512B
        run_chunk(64'h0000_0002_0000_0600, 3'b101, 1, 1'b1);
        // blocked by credit, then by turn, in WAIT
        run_chunk(64'h0000_0000_0000_1000, 3'b001, 2, 1'b1);

        // tag wrap 31 -> 0
        for (int k = 0; k < 7; k++) begin
            if (k % 2 == 1) run_chunk(64'h0000_0003_0000_0000 + 64'(k) * 64'h200, 3'b000, 0, 1'b1);
            else            run_chunk(64'h0000_0000_0010_0000 + 64'(k) * 64'h200, 3'b000, 0, 1'b1);
        end

        // reset while HDR0 is stalled
        trn_tdst_rdy_n = 1'b1;
        cfg_max_rd_req_size = 3'b000;
        huge_page_addr_read_from = 64'h0000_0000_0004_0000;
        @(posedge trn_clk); #1;
        read_chunk = 1'b1;
        cyc = 0;
        while (trn_tsof_n && cyc < 20) begin
            @(posedge trn_clk); #1;
            cyc++;
        end
        check_eq("reach_hdr0", trn_tsof_n, 1'b0);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_src_rdy", trn_tsrc_rdy_n, 1'b1);
        check_eq("mid_rst_sof",     trn_tsof_n,     1'b1);
        check_eq("mid_rst_driving", rd_req_driving, 1'b0);
        check_eq("mid_rst_td",      trn_td,         64'h0);
        read_chunk = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge trn_clk);
        #1;
        reset = 1'b0;
        trn_tdst_rdy_n = 1'b0;
        exp_tag = 0;

        // tag restarts at 0 after reset
        push_beat(64'h2000_0080_0100_00FF, 8'h00, 1'b0, 1'b1);
        push_beat(64'h0000_0001_2340_0200, 8'h00, 1'b1, 1'b0);
        run_chunk(64'h0000_0001_2340_0200, 3'b010, 0, 1'b0);

        repeat (4) @(posedge trn_clk);
        check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
